// File: rtl/fclk_soft_mute_if.sv
// Sample-path bundle between the I2S receiver side and the soft-mute conditioner.
interface fclk_soft_mute_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] data_left_in;
    logic [WIDTH-1:0] data_right_in;
    logic             mute_req;
    logic [WIDTH-1:0] data_left_out;
    logic [WIDTH-1:0] data_right_out;
    logic             out_valid;
    logic             muted;
    logic             clip_led;

    modport master (
        output in_valid, data_left_in, data_right_in, mute_req,
        input  data_left_out, data_right_out, out_valid, muted, clip_led
    );

    modport slave (
        input  in_valid, data_left_in, data_right_in, mute_req,
        output data_left_out, data_right_out, out_valid, muted, clip_led
    );
endinterface

// File: rtl/fclk_soft_mute.sv
// Frame-rate stereo conditioner: linear soft-mute gain ramp, 2-stage multiply
// pipeline and a stretched full-scale (clip) indicator.
module fclk_soft_mute #(
    parameter int WIDTH     = 32,
    parameter int RAMP_BITS = 6,
    parameter int CLIP_HOLD = 4800
) (
    input  logic           pin_i2s_fclk,
    input  logic           rst,
    fclk_soft_mute_if.slave bus
);
    localparam int GW = RAMP_BITS + 1;
    localparam int PW = WIDTH + RAMP_BITS + 2;
    localparam int CW = $clog2(CLIP_HOLD + 1);
    localparam logic [GW-1:0]    G_MAX     = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [WIDTH-1:0] FS_POS    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FS_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CLIP_LOAD = CW'(CLIP_HOLD);

    typedef enum logic [1:0] {MUTED, RAMP_UP, UNITY, RAMP_DOWN} state_t;

    state_t              state_reg, state_next;
    logic [GW-1:0]       g_reg, g_next;
    logic [1:0]          mute_sync_reg;
    logic                mute_s;
    logic [1:0][WIDTH-1:0] in_data;
    logic [1:0][WIDTH-1:0] s1_data_reg;
    logic [GW-1:0]       s1_g_reg;
    logic                s1_valid_reg;
    logic [1:0][WIDTH-1:0] scaled;
    logic [1:0][WIDTH-1:0] out_data_reg;
    logic                out_valid_reg;
    logic [CW-1:0]       clip_cnt_reg;
    logic                clip_led_reg;
    logic                fs_hit;

    assign in_data = {bus.data_right_in, bus.data_left_in};

    // Mute request comes from an unrelated domain; resets to "muted".
    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) mute_sync_reg <= 2'b11;
        else     mute_sync_reg <= {mute_sync_reg[0], bus.mute_req};
    end
    assign mute_s = mute_sync_reg[1];

    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            state_reg <= MUTED;
            g_reg     <= '0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
        end
    end

    // Direction and step are decided in the same cycle, so a reversal
    // continues from the current gain without a jump.
    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        case (state_reg)
            MUTED: begin
                if (!mute_s) begin
                    state_next = RAMP_UP;
                    if (bus.in_valid) g_next = g_reg + GW'(1);
                end
            end
            UNITY: begin
                if (mute_s) begin
                    state_next = RAMP_DOWN;
                    if (bus.in_valid) g_next = g_reg - GW'(1);
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (mute_s) begin
                    state_next = RAMP_DOWN;
                    if (g_reg == '0) begin
                        state_next = MUTED;
                    end else if (bus.in_valid) begin
                        g_next = g_reg - GW'(1);
                        if (g_reg == GW'(1)) state_next = MUTED;
                    end
                end else begin
                    state_next = RAMP_UP;
                    if (g_reg == G_MAX) begin
                        state_next = UNITY;
                    end else if (bus.in_valid) begin
                        g_next = g_reg + GW'(1);
                        if (g_reg == G_MAX - GW'(1)) state_next = UNITY;
                    end
                end
            end
        endcase
    end

    // Sign-extended operands; the low WIDTH bits above RAMP_BITS of the wide
    // product are exactly the floor-shifted result.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [PW-1:0] data_ext;
            logic [PW-1:0] gain_ext;
            logic [PW-1:0] prod;
            assign data_ext   = {{(PW-WIDTH){s1_data_reg[gi][WIDTH-1]}}, s1_data_reg[gi]};
            assign gain_ext   = {{(PW-GW){1'b0}}, s1_g_reg};
            assign prod       = data_ext * gain_ext;
            assign scaled[gi] = WIDTH'(prod >> RAMP_BITS);
        end
    endgenerate

    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            s1_data_reg   <= '0;
            s1_g_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= bus.in_valid;
            out_valid_reg <= s1_valid_reg;
            if (bus.in_valid) begin
                s1_data_reg <= in_data;
                s1_g_reg    <= g_reg;
            end
            if (s1_valid_reg) out_data_reg <= scaled;
        end
    end

    assign fs_hit = (in_data[0] == FS_POS) || (in_data[0] == FS_NEG) ||
                    (in_data[1] == FS_POS) || (in_data[1] == FS_NEG);

    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            clip_cnt_reg <= '0;
            clip_led_reg <= 1'b0;
        end else if (bus.in_valid) begin
            if (fs_hit) begin
                clip_cnt_reg <= CLIP_LOAD;
                clip_led_reg <= 1'b1;
            end else if (clip_cnt_reg != '0) begin
                clip_cnt_reg <= clip_cnt_reg - CW'(1);
                if (clip_cnt_reg == CW'(1)) clip_led_reg <= 1'b0;
            end
        end
    end

    assign bus.data_left_out  = out_data_reg[0];
    assign bus.data_right_out = out_data_reg[1];
    assign bus.out_valid      = out_valid_reg;
    assign bus.muted          = (state_reg == MUTED);
    assign bus.clip_led       = clip_led_reg;
endmodule
